// File: rtl/chunked_borrow_subtractor.sv
// Multi-cycle unsigned subtractor: diff = a - b, CHUNK bits per clock through a ripple-borrow chain.
// Optional macro SUB_SATURATE_EN clamps a borrowing result to zero.
module chunked_borrow_subtractor #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic [1:0]       o_dbg_state
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
    // in_ready/out_valid are registered; the source holds a/b/in_valid until in_ready is seen.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;
    logic             r_zero;

    logic [CHUNK:0]   w_sub;
    logic [CHUNK-1:0] w_d;
    logic             w_bo;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_final;

    assign w_sub = {1'b0, r_a[CHUNK-1:0]} - {1'b0, r_b[CHUNK-1:0]} - {{CHUNK{1'b0}}, r_borrow};
    assign w_d   = w_sub[CHUNK-1:0];
    assign w_bo  = w_sub[CHUNK];

    // The minuend register doubles as the result register: each difference chunk
    // enters at the top as the consumed chunk leaves the bottom.
    generate
        if (CHUNK == WIDTH) begin : g_single
            assign w_a_next = w_d;
        end else begin : g_multi
            assign w_a_next = {w_d, r_a[WIDTH-1:CHUNK]};
        end
    endgenerate

`ifdef SUB_SATURATE_EN
    assign w_final = w_bo ? '0 : w_a_next;
`else
    assign w_final = w_a_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_borrow     <= 1'b0;
            r_cnt        <= '0;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
            r_zero       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    if (in_valid && r_in_ready) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_borrow   <= 1'b0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a      <= w_a_next;
                    r_b      <= r_b >> CHUNK;
                    r_borrow <= w_bo;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CW'(NCHUNK - 1)) begin
                        r_diff       <= w_final;
                        r_borrow_out <= w_bo;
                        r_zero       <= (w_final == '0);
                        r_out_valid  <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign diff        = r_diff;
    assign borrow      = r_borrow_out;
    assign zero        = r_zero;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_chunked_borrow_subtractor.sv
// Self-checking bench for chunked_borrow_subtractor: vector table, corner sequences, random traffic.
module tb_chunked_borrow_subtractor;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int TMO    = 50;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zero;
  logic [1:0]       dbg_state;

  chunked_borrow_subtractor #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow     (borrow),
    .zero       (zero),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n_vec = 0;
  int n_err = 0;
  logic [WIDTH-1:0] exp_q[$];

  typedef struct {
    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] vb;
    logic [WIDTH-1:0] vd;
    logic             vbo;
    logic             vz;
    int               stall;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // reference model: plain modular arithmetic on the whole word
  function automatic void model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                output logic [WIDTH-1:0] md, output logic mbo, output logic mz);
    mbo = (ma < mb);
    md  = ma - mb;
`ifdef SUB_SATURATE_EN
    if (mbo) md = '0;
`endif
    mz = (md == '0);
  endfunction

  // driver: one full transaction with a chosen number of out_ready stall cycles
  task automatic run_txn(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                         input logic [WIDTH-1:0] ed, input logic eb, input logic ez,
                         input int stall, input string tag);
    int n;
    @(negedge clk);
    a = ta;
    b = tb_v;
    in_valid = 1'b1;
    out_ready = (stall == 0);
    n = 0;
    while (!in_ready && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check({tag, " accept_timeout"}, 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    n = 0;
    while (!out_valid && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(NCHUNK));
    if (!out_valid) return;
    check({tag, " diff"}, 32'(diff), 32'(ed));
    check({tag, " borrow_zero"}, {30'd0, borrow, zero}, {30'd0, eb, ez});
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, " hold"}, {12'd0, out_valid, in_ready, borrow, zero, diff},
            {12'd0, 1'b1, 1'b0, eb, ez, ed});
    end
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, " release"}, {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
    out_ready = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] md, ra, rb;
    logic mbo, mz, in_ready_leak, spurious;
    int n;

    vecs[0] = '{16'h1234, 16'h0034, 16'h1200, 1'b0, 1'b0, 0};
    vecs[1] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 0};
    vecs[2] = '{16'h8F0F, 16'h8F0F, 16'h0000, 1'b0, 1'b1, 1};
    vecs[3] = '{16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0, 0};
    vecs[4] = '{16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 2};
    vecs[5] = '{16'h0001, 16'hFFFF, 16'h0002, 1'b1, 1'b0, 0};
    vecs[6] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 3};
    vecs[7] = '{16'hABCD, 16'h0000, 16'hABCD, 1'b0, 1'b0, 10};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    #1;
    check("reset_outputs", {11'd0, in_ready, out_valid, borrow, zero, diff},
          {11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", {29'd0, in_ready, dbg_state}, {29'd0, 1'b1, 2'd0});

    // table-driven vectors
    for (int i = 0; i < 8; i++) begin
      md = vecs[i].vd;
      mz = vecs[i].vz;
`ifdef SUB_SATURATE_EN
      if (vecs[i].vbo) begin
        md = '0;
        mz = 1'b1;
      end
`endif
      run_txn(vecs[i].va, vecs[i].vb, md, vecs[i].vbo, mz, vecs[i].stall, $sformatf("vec%0d", i));
    end

    // reset during RUN cycle 2 aborts the operation (diff is 0xABCD beforehand)
    @(negedge clk);
    a = 16'h5555;
    b = 16'h1111;
    in_valid = 1'b1;
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < TMO) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("abort_in_run", 32'(dbg_state), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_immediate", {14'd0, out_valid, in_ready, diff}, {14'd0, 1'b0, 1'b0, 16'h0000});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready", 32'(in_ready), 32'd1);
    spurious = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) spurious = 1'b1;
    end
    check("abort_no_result", 32'(spurious), 32'd0);

    // back-to-back with in_valid held high
    out_ready = 1'b1;
    model(16'hFFFF, 16'h0001, md, mbo, mz);
    exp_q.push_back(md);
    model(16'h0001, 16'hFFFF, md, mbo, mz);
    exp_q.push_back(md);
    @(negedge clk);
    a = 16'hFFFF;
    b = 16'h0001;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < TMO) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    a = 16'h0001;
    b = 16'hFFFF;
    in_ready_leak = 1'b0;
    n = 0;
    while (!out_valid && n < TMO) begin
      if (in_ready) in_ready_leak = 1'b1;
      @(negedge clk);
      n++;
    end
    check("b2b1 latency", 32'(n), 32'(NCHUNK));
    check("b2b1 diff", 32'(diff), 32'(exp_q.pop_front()));
    check("b2b1 borrow", 32'(borrow), 32'd0);
    check("b2b1 ready_low", 32'(in_ready_leak | in_ready), 32'd0);
    @(negedge clk);
    check("b2b gap", {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b second_accept", {29'd0, in_ready, dbg_state}, {29'd0, 1'b0, 2'd1});
    n = 0;
    while (!out_valid && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check("b2b2 latency", 32'(n), 32'(NCHUNK));
    check("b2b2 diff", 32'(diff), 32'(exp_q.pop_front()));
    check("b2b2 borrow", 32'(borrow), 32'd1);
    @(negedge clk);
    out_ready = 1'b0;

    // randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      ra = WIDTH'($urandom_range(0, 65535));
      rb = ($urandom_range(0, 4) == 0) ? ra : WIDTH'($urandom_range(0, 65535));
      model(ra, rb, md, mbo, mz);
      run_txn(ra, rb, md, mbo, mz, $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
